// File: rtl/mar_ram.sv
// Memory address register plus 16x8 program RAM with a byte-serial loader.
// After reset the block loads 16 bytes, then serves MAR-addressed reads and writes.
module mar_ram (
  input  logic       clock,
  input  logic       reset,
  input  logic       mar_in,
  input  logic       ram_in,
  input  logic       ram_out,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [3:0] mar_q,
  input  logic       prog_valid,
  input  logic [7:0] prog_data,
  output logic       prog_ready,
  output logic       prog_done,
  input  logic       prog_restart
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ldp_q, ldp_d;
  logic [3:0] mar_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q, bus_oe_d;
  logic       prog_done_q, prog_done_d;

  logic       xfer;
  logic       run_wr;
  logic       run_rd;
  logic       mar_ld;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  logic [7:0] mem [16];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what gives read-before-write and old-MAR access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (prog_restart) begin
      state_d = ST_LOAD;
    end else if (state_q == ST_LOAD && prog_valid && ldp_q == 4'hF) begin
      state_d = ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (restart blocks every state-changing action on its edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    prog_ready = (state_q == ST_LOAD);
    xfer       = 1'b0;
    run_wr     = 1'b0;
    run_rd     = 1'b0;
    mar_ld     = 1'b0;
    if (!prog_restart) begin
      if (state_q == ST_LOAD) begin
        xfer = prog_valid;
      end else begin
        run_wr = ram_in;
        run_rd = ram_out;
        mar_ld = mar_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    ldp_d       = ldp_q;
    mar_d       = mar_q;
    bus_oe_d    = run_rd;
    bus_out_d   = run_rd ? mem[mar_q] : 8'h00;
    prog_done_d = (state_d == ST_RUN);
    mem_we      = 1'b0;
    mem_addr    = mar_q;
    mem_wdata   = bus_in;

    if (prog_restart) begin
      ldp_d = 4'h0;
    end else if (xfer) begin
      ldp_d     = ldp_q + 4'h1;
      mem_we    = 1'b1;
      mem_addr  = ldp_q;
      mem_wdata = prog_data;
    end

    if (mar_ld) begin
      mar_d = bus_in[3:0];
    end
    // Write address is the MAR before this edge, even if mar_in loads a new one.
    if (run_wr) begin
      mem_we    = 1'b1;
      mem_addr  = mar_q;
      mem_wdata = bus_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ldp_q       <= 4'h0;
      mar_q       <= 4'h0;
      bus_oe_q    <= 1'b0;
      bus_out_q   <= 8'h00;
      prog_done_q <= 1'b0;
    end else begin
      ldp_q       <= ldp_d;
      mar_q       <= mar_d;
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
      prog_done_q <= prog_done_d;
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset and restart, and
  // reset only suppresses the write on its own edge.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign prog_done = prog_done_q;

endmodule

// File: tb/tb_mar_ram.sv
// Scoreboard bench for mar_ram: stimulus pushes expected read bytes, a
// negedge monitor pops them whenever bus_oe is seen.
module tb_mar_ram;

  logic       clock = 1'b0;
  logic       reset;
  logic       mar_in, ram_in, ram_out;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [3:0] mar_q;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic       prog_restart;

  int n_checks = 0;
  int n_fail   = 0;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q [$];

  mar_ram dut (
    .clock       (clock),
    .reset       (reset),
    .mar_in      (mar_in),
    .ram_in      (ram_in),
    .ram_out     (ram_out),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .mar_q       (mar_q),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_ready  (prog_ready),
    .prog_done   (prog_done),
    .prog_restart(prog_restart)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic transfer(input logic [7:0] data);
    prog_valid = 1'b1;
    prog_data  = data;
    step();
    prog_valid = 1'b0;
  endtask

  task automatic read_at(input logic [3:0] addr, input logic [7:0] expected);
    mar_in = 1'b1;
    bus_in = {4'h0, addr};
    step();
    mar_in  = 1'b0;
    ram_out = 1'b1;
    exp_q.push_back(expected);
    step();
    ram_out = 1'b0;
  endtask

  // Monitor: every bus_oe beat must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus_oe === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bus_oe", {24'h0, bus_out}, 32'hFFFF_FFFF);
        end else begin
          check("bus_out", {24'h0, bus_out}, {24'h0, exp_q.pop_front()});
        end
      end else begin
        check("bus_out_idle", {24'h0, bus_out}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mar_in = 1'b0; ram_in = 1'b0; ram_out = 1'b0;
    bus_in = 8'h00; prog_valid = 1'b0; prog_data = 8'h00; prog_restart = 1'b0;
    step();
    step();
    mon_en = 1'b1;
    check("rst_prog_ready", {31'h0, prog_ready}, 32'h1);
    check("rst_prog_done",  {31'h0, prog_done},  32'h0);
    check("rst_mar",        {28'h0, mar_q},      32'h0);
    check("rst_bus_oe",     {31'h0, bus_oe},     32'h0);
    reset = 1'b1;

    // Load 0x10..0x1F; done must rise exactly on the 16th edge.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("done_before_16th", {31'h0, prog_done}, 32'h0);
      transfer(8'h10 + 8'(i));
    end
    check("done_after_16th",  {31'h0, prog_done},  32'h1);
    check("ready_after_16th", {31'h0, prog_ready}, 32'h0);

    // RUN: MAR=5, read -> 0x15.
    read_at(4'h5, 8'h15);
    check("mar_after_load5", {28'h0, mar_q}, 32'h5);

    // Write 0xAB at MAR=5 with coincident read -> old 0x15, then 0xAB.
    ram_in = 1'b1; ram_out = 1'b1; bus_in = 8'hAB;
    exp_q.push_back(8'h15);
    step();
    ram_in = 1'b0;
    exp_q.push_back(8'hAB);
    step();
    ram_out = 1'b0;

    // mar_in 0xF3 with ram_out: data from old MAR 5, MAR becomes 3.
    mar_in = 1'b1; ram_out = 1'b1; bus_in = 8'hF3;
    exp_q.push_back(8'hAB);
    step();
    mar_in = 1'b0;
    check("mar_f3_low_nibble", {28'h0, mar_q}, 32'h3);
    // ram_out held: back-to-back reads of RAM[3].
    exp_q.push_back(8'h13);
    step();
    exp_q.push_back(8'h13);
    step();
    ram_out = 1'b0;

    // prog_valid is ignored in RUN.
    prog_valid = 1'b1; prog_data = 8'h99;
    step();
    prog_valid = 1'b0;
    read_at(4'h0, 8'h10);
    check("run_ignores_prog", {31'h0, prog_done}, 32'h1);

    // Restart coincident with a transfer: LOAD, done=0, MAR retained, no write.
    mar_in = 1'b1; bus_in = 8'h03;
    step();
    mar_in = 1'b0;
    prog_restart = 1'b1; prog_valid = 1'b1; prog_data = 8'h77;
    step();
    prog_restart = 1'b0; prog_valid = 1'b0;
    check("restart_done",  {31'h0, prog_done},  32'h0);
    check("restart_ready", {31'h0, prog_ready}, 32'h1);
    check("restart_mar",   {28'h0, mar_q},      32'h3);

    // LOAD ignores mar_in/ram_in/ram_out (monitor expects no bus_oe).
    mar_in = 1'b1; ram_in = 1'b1; ram_out = 1'b1; bus_in = 8'h09;
    step();
    mar_in = 1'b0; ram_in = 1'b0; ram_out = 1'b0;
    check("load_holds_mar", {28'h0, mar_q}, 32'h3);

    // Partial load of 7, then reset discards the count.
    for (int i = 0; i < 7; i++) transfer(8'h30 + 8'(i));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midload_rst_mar", {28'h0, mar_q}, 32'h0);
    for (int i = 0; i < 16; i++) transfer(8'h20 + 8'(i));
    check("reload_done", {31'h0, prog_done}, 32'h1);
    for (int i = 0; i < 16; i++) read_at(4'(i), 8'h20 + 8'(i));

    step();
    step();
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mar_ram.md
MAR_RAM -- requirements
Module: mar_ram

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
REQ-003 SHALL have port mar_in, input, 1 bit: load MAR from bus_in[3:0].
REQ-004 SHALL have port ram_in, input, 1 bit: write bus_in[7:0] to RAM[MAR].
REQ-005 SHALL have port ram_out, input, 1 bit: drive RAM[MAR] onto bus_out.
REQ-006 SHALL have port bus_in, input, 8 bits: shared bus value, typically the program-counter or accumulator output.
REQ-007 SHALL have port bus_out, output, 8 bits: registered RAM read data.
REQ-008 SHALL have port bus_oe, output, 1 bit: bus_out valid and driving the bus.
REQ-009 SHALL have port mar_q, output, 4 bits: current MAR value.
REQ-010 SHALL have port prog_valid, input, 1 bit: loader byte valid.
REQ-011 SHALL have port prog_data, input, 8 bits: loader byte.
REQ-012 SHALL have port prog_ready, output, 1 bit: block accepting loader bytes.
REQ-013 SHALL have port prog_done, output, 1 bit: 16 bytes loaded; block in RUN.
REQ-014 SHALL have port prog_restart, input, 1 bit: return to LOAD and reload from address 0.

Function
REQ-015 SHALL contain a 16 x 8 RAM, a 4-bit MAR, and a 4-bit load pointer ldp.
REQ-016 SHALL implement a two-state FSM with states LOAD and RUN.
REQ-017 SHALL drive prog_ready = (state == LOAD) combinationally; prog_done SHALL be registered and equal 1 exactly while the FSM is in RUN.
REQ-018 SHALL treat a rising edge in LOAD with prog_valid=1 as a transfer: RAM[ldp] <= prog_data, ldp <= ldp+1.
REQ-019 SHALL, on a transfer with ldp==15, wrap ldp to 0, enter RUN, and set prog_done=1 on the same edge.
REQ-020 SHALL leave RAM and ldp unchanged in LOAD when prog_valid=0.
REQ-021 SHALL ignore mar_in, ram_in and ram_out in LOAD: MAR held, bus_oe=0, bus_out=0x00.
REQ-022 SHALL ignore prog_valid and prog_data in RUN.
REQ-023 SHALL, in RUN, set MAR <= bus_in[3:0] on an edge with mar_in=1; bus_in[7:4] ignored.
REQ-024 SHALL, in RUN, write RAM[MAR] <= bus_in on an edge with ram_in=1, using the MAR value before that edge.
REQ-025 SHALL, in RUN, on every edge set bus_oe <= ram_out and bus_out <= (ram_out ? RAM[MAR] : 0x00), giving 1-cycle read latency.
REQ-026 SHALL read old contents when ram_in and ram_out are both asserted on one edge (read-before-write).
REQ-027 SHALL read and write at the old MAR when mar_in coincides with ram_out or ram_in; the new MAR applies from the next edge.
REQ-028 SHALL produce a back-to-back read when ram_out is held high, re-reading RAM[MAR] every cycle.
REQ-029 SHALL, on an edge with prog_restart=1 in either state, set state=LOAD, ldp=0, prog_done=0, bus_oe=0, bus_out=0x00; RAM and MAR are retained.
REQ-030 SHALL give prog_restart priority over a coincident transfer; that byte is not written.

Reset
REQ-031 SHALL, on an edge with reset=0, set state=LOAD, ldp=0, MAR=0, prog_done=0, bus_oe=0, bus_out=0x00.
REQ-032 SHALL give reset priority over all other inputs.
REQ-033 SHALL not clear RAM contents on reset.
REQ-034 SHALL, when reset is asserted mid-load, discard the partial count; the next transfer writes address 0.

Verification
REQ-035 Bench SHALL cover: reset, then 16 transfers of bytes 0x10..0x1F -> prog_done=1 on the 16th edge, prog_ready=0 afterward.
REQ-036 Bench SHALL cover: in RUN, mar_in with bus_in=0x05, then ram_out -> bus_out=0x15, bus_oe=1 one cycle after ram_out is sampled.
REQ-037 Bench SHALL cover: ram_in with bus_in=0xAB at MAR=5, ram_out on the same edge -> bus_out=0x15; next ram_out -> 0xAB.
REQ-038 Bench SHALL cover: mar_in with bus_in=0xF3 and ram_out on the same edge -> data read from the old MAR; MAR becomes 3.
REQ-039 Bench SHALL cover: reset=0 after 7 transfers, then 16 transfers of 0x20..0x2F -> RAM[0..15] = 0x20..0x2F.
REQ-040 Bench SHALL cover: prog_restart in RUN coincident with prog_valid=1 -> state LOAD, prog_done=0, ldp=0, no RAM write, MAR retained.
